mux_seq_sel: RTL and testbench

Parametrised successor to the 16-bit 2:1 mux: an N-way, WIDTH-bit lane selector with a registered output stage and valid/ready handshakes. In direct mode it forwards one selected lane per transfer. In sequence mode it captures a whole N-lane vector and serialises lanes 0..L-1 onto the output, one per beat. It sits between the vector register/memory read path and the scalar ALU operand port of the memory-to-memory datapath.

---
 rtl/mux_seq_sel_pkg.sv | 16 +
 rtl/mux_nb.sv | 24 ++
 rtl/mux_seq_sel.sv | 145 ++++++++++++++
 tb/tb_mux_seq_sel.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_sel_pkg.sv
// Shared definitions for the mux_seq_sel lane selector.
// Contents:
//   - mode encodings, sampled at accept
//   - FSM state encodings
package mux_seq_sel_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SEQ    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LAST = 2'd1,
    ST_SEQ  = 2'd2
  } state_e;

endpackage

// File: rtl/mux_nb.sv
// Purely combinational N-way WIDTH-bit lane selector.
// Ports:
//   data - N flattened lanes, lane i = data[i*WIDTH +: WIDTH]
//   sel  - lane index
//   y_c  - selected lane, or 0 when sel >= N
module mux_nb #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   y_c
);

  // One-hot compare per lane; no match (out-of-range index) leaves zero.
  always_comb begin
    y_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (sel == SEL_W'(i)) y_c = data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_seq_sel.sv
// N-way lane selector with registered output stage and valid/ready handshakes.
// Direct mode forwards one selected lane per transfer; sequence mode captures
// the whole lane vector and serialises lanes 0..L-1, one per beat.
// Ports:
//   clk, reset_n            - clock, async active-low reset
//   in_data/mode/s/in_valid - request (sampled at accept), in_ready back
//   out_data/out_sel/out_last/out_valid - registered beat, out_ready back
//   busy                    - more sequence beats remain after the current one
module mux_seq_sel
  import mux_seq_sel_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic               mode,
  input  logic [SEL_W-1:0]   s,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam logic [SEL_W-1:0] MAX_IDX = SEL_W'(N - 1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [SEL_W-1:0]     lidx_q, lidx_d;
  logic [N*WIDTH-1:0]   hold_q, hold_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 olast_q, olast_d;

  logic                 accept;
  logic                 beat;
  logic [SEL_W-1:0]     idx_inc;
  logic [WIDTH-1:0]     direct_lane;
  logic [WIDTH-1:0]     seq_lane;

  // Handshake decode; in_ready never looks at in_valid.
  assign out_valid = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_LAST) & out_ready);
  assign accept    = in_valid & in_ready;
  assign beat      = out_valid & out_ready;
  assign busy      = (state_q == ST_SEQ);
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_last  = olast_q;

  // Index never exceeds L-1 <= N-1, so the increment cannot wrap.
  assign idx_inc = idx_q + SEL_W'(1);

  mux_nb #(.WIDTH(WIDTH), .N(N)) u_direct_mux (
    .data (in_data),
    .sel  (s),
    .y_c  (direct_lane)
  );

  mux_nb #(.WIDTH(WIDTH), .N(N)) u_seq_mux (
    .data (hold_q),
    .sel  (idx_inc),
    .y_c  (seq_lane)
  );

  // Next-state and next-output logic; a new accept takes priority so the
  // final beat of one transfer can hand over with no bubble.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lidx_d  = lidx_q;
    hold_d  = hold_q;
    data_d  = data_q;
    sel_d   = sel_q;
    olast_d = olast_q;

    if (accept) begin
      case (mode)
        MODE_DIRECT: begin
          data_d  = direct_lane;
          sel_d   = s;
          olast_d = 1'b1;
          state_d = ST_LAST;
        end
        MODE_SEQ: begin
          hold_d  = in_data;
          data_d  = in_data[WIDTH-1:0];
          sel_d   = '0;
          idx_d   = '0;
          lidx_d  = (s > MAX_IDX) ? MAX_IDX : s;
          if (s == '0) begin
            olast_d = 1'b1;
            state_d = ST_LAST;
          end else begin
            olast_d = 1'b0;
            state_d = ST_SEQ;
          end
        end
        default: ;
      endcase
    end else if (beat) begin
      case (state_q)
        ST_SEQ: begin
          idx_d  = idx_inc;
          data_d = seq_lane;
          sel_d  = idx_inc;
          if (idx_inc == lidx_q) begin
            olast_d = 1'b1;
            state_d = ST_LAST;
          end
        end
        ST_LAST: state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lidx_q  <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lidx_q  <= lidx_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      olast_q <= olast_d;
    end
  end

endmodule

// File: tb/tb_mux_seq_sel.sv
module tb_mux_seq_sel;

  localparam logic [63:0] LANES  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  localparam logic [47:0] LANES3 = {16'h3333, 16'h2222, 16'h1111};

  logic        clk;
  logic        reset_n;
  logic [63:0] in_data;
  logic        mode;
  logic [1:0]  s;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic [47:0] in_data3;
  logic        mode3;
  logic [1:0]  s3;
  logic        in_valid3;
  logic        in_ready3;
  logic [15:0] out_data3;
  logic [1:0]  out_sel3;
  logic        out_last3;
  logic        out_valid3;
  logic        out_ready3;
  logic        busy3;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  sel;
    logic        last;
  } beat_t;

  beat_t q[$];

  mux_seq_sel #(.WIDTH(16), .N(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .mode(mode), .s(s),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  mux_seq_sel #(.WIDTH(16), .N(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data3), .mode(mode3), .s(s3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_sel(out_sel3), .out_last(out_last3), .out_valid(out_valid3),
    .out_ready(out_ready3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a queue of beats still owed to the consumer.
  always @(negedge reset_n) q.delete();

  always @(posedge clk) begin
    if (reset_n) begin
      bit    m_rdy;
      beat_t b;
      int    len;
      m_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && m_rdy) begin
        if (mode == 1'b0) begin
          b.d    = (int'(s) < 4) ? in_data[int'(s)*16 +: 16] : 16'h0;
          b.sel  = s;
          b.last = 1'b1;
          q.push_back(b);
        end else begin
          len = (int'(s) + 1 < 4) ? int'(s) + 1 : 4;
          for (int i = 0; i < len; i++) begin
            b.d    = in_data[i*16 +: 16];
            b.sel  = 2'(i);
            b.last = (i == len - 1);
            q.push_back(b);
          end
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("m_busy", 32'(busy), 32'(q.size() > 1));
      chk("m_in_ready", 32'(in_ready), 32'((q.size() == 0) || (q.size() == 1 && out_ready)));
      if (q.size() != 0 && out_valid) begin
        chk("m_out_data", 32'(out_data), 32'(q[0].d));
        chk("m_out_sel", 32'(out_sel), 32'(q[0].sel));
        chk("m_out_last", 32'(out_last), 32'(q[0].last));
      end
    end
  end

  task automatic step(input logic v, input logic m, input logic [1:0] sel, input logic rdy);
    in_valid  = v;
    mode      = m;
    s         = sel;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input logic v, input logic m, input logic [1:0] sel);
    in_valid3 = v;
    mode3     = m;
    s3        = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_data    = LANES;
    mode       = 1'b0;
    s          = 2'd0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in_data3   = LANES3;
    mode3      = 1'b0;
    s3         = 2'd0;
    in_valid3  = 1'b0;
    out_ready3 = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Direct mode, full throughput.
    step(1, 0, 2'd0, 1); chk("d0_data", 32'(out_data), 32'h1111); chk("d0_rdy", 32'(in_ready), 32'd1);
    step(1, 0, 2'd1, 1); chk("d1_data", 32'(out_data), 32'h2222); chk("d1_last", 32'(out_last), 32'd1);
    step(1, 0, 2'd2, 1); chk("d2_data", 32'(out_data), 32'h3333);
    step(1, 0, 2'd3, 1); chk("d3_data", 32'(out_data), 32'h4444); chk("d3_rdy", 32'(in_ready), 32'd1);
    step(0, 0, 2'd0, 1); chk("d_idle", 32'(out_valid), 32'd0);

    // Direct mode with stall; in_data changes after accept.
    step(1, 0, 2'd2, 0);
    in_data = 64'hdead_beef_cafe_f00d;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 2'd1, 0);
      chk("stall_data", 32'(out_data), 32'h3333);
      chk("stall_sel", 32'(out_sel), 32'd2);
      chk("stall_rdy", 32'(in_ready), 32'd0);
    end
    step(0, 0, 2'd0, 1); chk("stall_done", 32'(out_valid), 32'd0);
    in_data = LANES;

    // Sequence mode, four beats.
    step(1, 1, 2'd3, 1);
    chk("s1_data", 32'(out_data), 32'h1111); chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_last", 32'(out_last), 32'd0); chk("s1_rdy", 32'(in_ready), 32'd0);
    step(0, 0, 2'd0, 1); chk("s2_data", 32'(out_data), 32'h2222); chk("s2_sel", 32'(out_sel), 32'd1);
    step(0, 0, 2'd0, 1); chk("s3_data", 32'(out_data), 32'h3333); chk("s3_busy", 32'(busy), 32'd1);
    step(0, 0, 2'd0, 1);
    chk("s4_data", 32'(out_data), 32'h4444); chk("s4_last", 32'(out_last), 32'd1);
    chk("s4_busy", 32'(busy), 32'd0); chk("s4_rdy", 32'(in_ready), 32'd1);
    step(0, 0, 2'd0, 1); chk("s_idle", 32'(out_valid), 32'd0);

    // Two-beat sequence with stall, then back-to-back direct request.
    step(1, 1, 2'd1, 1); chk("b1_data", 32'(out_data), 32'h1111);
    step(1, 0, 2'd3, 1); chk("b2_data", 32'(out_data), 32'h2222); chk("b2_last", 32'(out_last), 32'd1);
    step(1, 0, 2'd3, 0); chk("b2_hold", 32'(out_data), 32'h2222); chk("b2_rdy", 32'(in_ready), 32'd0);
    step(1, 0, 2'd3, 1); chk("b3_data", 32'(out_data), 32'h4444); chk("b3_valid", 32'(out_valid), 32'd1);
    step(0, 0, 2'd0, 1);

    // Reset mid-sequence.
    step(1, 1, 2'd3, 1);
    step(0, 0, 2'd0, 1);
    step(0, 0, 2'd0, 1); chk("r_pre", 32'(out_data), 32'h3333);
    #2 reset_n = 1'b0;
    #1;
    chk("r_valid", 32'(out_valid), 32'd0); chk("r_data", 32'(out_data), 32'd0);
    chk("r_sel", 32'(out_sel), 32'd0); chk("r_last", 32'(out_last), 32'd0);
    chk("r_busy", 32'(busy), 32'd0); chk("r_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'd0, 1);
      chk("r_after", 32'(out_valid), 32'd0);
    end

    // N=3 instance: out-of-range direct index and clamped sequence length.
    step3(1, 0, 2'd3);
    chk("n3_data", 32'(out_data3), 32'd0); chk("n3_sel", 32'(out_sel3), 32'd3);
    chk("n3_last", 32'(out_last3), 32'd1); chk("n3_valid", 32'(out_valid3), 32'd1);
    step3(1, 1, 2'd3); chk("n3s1", 32'(out_data3), 32'h1111); chk("n3s1_last", 32'(out_last3), 32'd0);
    step3(0, 0, 2'd0); chk("n3s2", 32'(out_data3), 32'h2222);
    step3(0, 0, 2'd0); chk("n3s3", 32'(out_data3), 32'h3333); chk("n3s3_last", 32'(out_last3), 32'd1);
    step3(0, 0, 2'd0); chk("n3_idle", 32'(out_valid3), 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
